gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised gshare direction predictor: a global history register (GHR) is XOR-ed with low PC bits to index a pattern history table (PHT) of 2-bit saturating counters. It is the next generation of the fixed 3-bit GHR/PHT predictor. It adds four capabilities:
- PC-hashed indexing.
- A registered prediction pipeline with history checkpoints.
- Speculative history update with mispredict recovery.
- Prediction/mispredict statistics.

It sits between fetch (prediction requests) and branch resolution (updates).

## Interface
- GHR_BITS, 3, history width; PHT has 2**GHR_BITS entries (must be 2..10)
- PC_BITS, 8, request PC width (must be >= GHR_BITS)
- CTR_INIT, 2'b01, PHT counter value after reset (weakly not-taken)
- STAT_BITS, 16, width of statistics counters
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pred_req  in  1  prediction request this cycle
- pred_pc  in  PC_BITS  branch PC of request
- pred_valid  out  1  registered; prediction outputs valid
- pred_taken  out  1  predicted direction (counter MSB)
- pred_idx  out  GHR_BITS  PHT index used; returned on update
- pred_ghr  out  GHR_BITS  GHR value before the speculative shift (checkpoint)
- upd_en  in  1  branch resolved this cycle
- upd_idx  in  GHR_BITS  PHT index from the matching prediction
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  resolved direction differed from prediction
- upd_ghr  in  GHR_BITS  checkpoint from the matching prediction
- ghr_out  out  GHR_BITS  current (speculative) GHR
- stat_preds  out  STAT_BITS  predictions issued
- stat_mispreds  out  STAT_BITS  mispredicts reported

## Operation
- Index: idx = pred_pc[GHR_BITS-1:0] ^ ghr. Counter cnt = pht[idx].
- Predict, when pred_req=1:
  - Next edge: pred_valid=1, pred_taken=cnt[1], pred_idx=idx, pred_ghr=ghr.
  - Speculative history: ghr <= {ghr[GHR_BITS-2:0], cnt[1]}.
  - pred_req=0 drives pred_valid=0 next cycle; the other prediction outputs hold their last values.
- Update, when upd_en=1:
  - pht[upd_idx] increments if upd_taken, decrements otherwise, saturating at 2'b11 and 2'b00.
  - If upd_mispredict=1, recover history: ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken}.
- Simultaneous predict and update:
  - The PHT read uses the pre-update value, including when upd_idx==idx. There is no bypass.
  - Recovery has priority over the speculative shift: the recovered GHR is loaded and the predicted bit is discarded. The prediction is still issued, computed with the old GHR.
- Statistics:
  - stat_preds increments on each pred_req.
  - stat_mispreds increments on each upd_en with upd_mispredict=1.
  - Both saturate at all-ones and never wrap.
- upd_mispredict with upd_en=0 is ignored.
- Reset, asynchronous at any time, including with a prediction in flight:
  - All PHT entries = CTR_INIT; ghr = 0.
  - pred_valid, pred_taken, pred_idx, pred_ghr = 0; both statistics = 0.
  - An in-flight prediction is dropped. Requests start again on the first edge after reset deasserts.

## Timing
- Prediction latency: 1 cycle, pred_req at edge N gives pred_valid at N+1. Throughput: 1 prediction per cycle.
- A back-to-back request at N+1 indexes with the GHR already shifted by the prediction made at N.
- An update is visible to PHT reads and to ghr_out from the next cycle.
- ghr_out, stat_preds and stat_mispreds are direct register outputs with no combinational path from inputs.
- No handshake back-pressure: every request and every update is accepted.

## Test plan
- Reset, then pred_req with pc=0x05 (GHR_BITS=3) -> next cycle pred_valid=1, pred_idx=5, pred_taken=0, pred_ghr=0; ghr_out=0 (predicted bit 0 shifted in); stat_preds=1.
- Four upd_en, upd_taken=1 on idx 5 -> counter 01→10→11→11 (saturates); a following predict at pc=0x05 with ghr=0 -> pred_taken=1, ghr_out=3'b001.
- Four updates with upd_taken=0 on a counter at 11 -> reaches 00 and holds; a following prediction at that index -> pred_taken=0.
- Set ghr=3'b101 speculatively, then upd_en=1, upd_mispredict=1, upd_ghr=3'b010, upd_taken=1 issued in the same cycle as a pred_req -> ghr_out=3'b101 next cycle; that request reports pred_ghr equal to the pre-recovery GHR; stat_mispreds=1.
- Same-cycle predict and update on the same index with the counter at 01 and upd_taken=1 -> pred_taken=0 (old value); the next predict on that index gives pred_taken=1.
- Assert reset mid-stream with pred_valid=1 -> pred_valid=0 immediately (asynchronous), ghr_out=0, statistics 0, all entries predict per CTR_INIT; drive stat_preds to all-ones with STAT_BITS=4 -> holds at 15.

Source files
------------

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with speculative GHR,
// mispredict recovery from per-prediction checkpoints and saturating statistics.
module gshare_predictor #(
  parameter int          GHR_BITS  = 3,
  parameter int          PC_BITS   = 8,
  parameter logic [1:0]  CTR_INIT  = 2'b01,
  parameter int          STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_req,
  input  logic [PC_BITS-1:0]   pred_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [GHR_BITS-1:0]  pred_idx,
  output logic [GHR_BITS-1:0]  pred_ghr,
  input  logic                 upd_en,
  input  logic [GHR_BITS-1:0]  upd_idx,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  input  logic [GHR_BITS-1:0]  upd_ghr,
  output logic [GHR_BITS-1:0]  ghr_out,
  output logic [STAT_BITS-1:0] stat_preds,
  output logic [STAT_BITS-1:0] stat_mispreds
);
  localparam int ENTRIES = 1 << GHR_BITS;

  logic [1:0]           pht_q [ENTRIES];
  logic [1:0]           pht_d [ENTRIES];
  logic [GHR_BITS-1:0]  ghr_q, ghr_d;
  logic                 pred_valid_q, pred_valid_d;
  logic                 pred_taken_q, pred_taken_d;
  logic [GHR_BITS-1:0]  pred_idx_q, pred_idx_d;
  logic [GHR_BITS-1:0]  pred_ghr_q, pred_ghr_d;
  logic [STAT_BITS-1:0] stat_preds_q, stat_preds_d;
  logic [STAT_BITS-1:0] stat_mispreds_q, stat_mispreds_d;

  logic [GHR_BITS-1:0]  idx;
  logic [1:0]           cnt;
  logic [1:0]           upd_cnt;
  logic                 unused_pc;

  // Only the low PC bits take part in the hash.
  assign unused_pc = ^pred_pc;

  always_comb begin
    idx             = pred_pc[GHR_BITS-1:0] ^ ghr_q;
    cnt             = pht_q[idx];
    upd_cnt         = pht_q[upd_idx];
    pht_d           = pht_q;
    ghr_d           = ghr_q;
    pred_valid_d    = pred_req;
    pred_taken_d    = pred_taken_q;
    pred_idx_d      = pred_idx_q;
    pred_ghr_d      = pred_ghr_q;
    stat_preds_d    = stat_preds_q;
    stat_mispreds_d = stat_mispreds_q;

    if (pred_req) begin
      pred_taken_d = cnt[1];
      pred_idx_d   = idx;
      pred_ghr_d   = ghr_q;
      ghr_d        = {ghr_q[GHR_BITS-2:0], cnt[1]};
      if (stat_preds_q != '1) stat_preds_d = stat_preds_q + 1'b1;
    end

    // PHT read above already captured the pre-update counter; recovery overrides the shift.
    if (upd_en) begin
      if (upd_taken) begin
        if (upd_cnt != 2'b11) pht_d[upd_idx] = upd_cnt + 2'b01;
      end else begin
        if (upd_cnt != 2'b00) pht_d[upd_idx] = upd_cnt - 2'b01;
      end
      if (upd_mispredict) begin
        ghr_d = {upd_ghr[GHR_BITS-2:0], upd_taken};
        if (stat_mispreds_q != '1) stat_mispreds_d = stat_mispreds_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
      ghr_q           <= '0;
      pred_valid_q    <= 1'b0;
      pred_taken_q    <= 1'b0;
      pred_idx_q      <= '0;
      pred_ghr_q      <= '0;
      stat_preds_q    <= '0;
      stat_mispreds_q <= '0;
    end else begin
      pht_q           <= pht_d;
      ghr_q           <= ghr_d;
      pred_valid_q    <= pred_valid_d;
      pred_taken_q    <= pred_taken_d;
      pred_idx_q      <= pred_idx_d;
      pred_ghr_q      <= pred_ghr_d;
      stat_preds_q    <= stat_preds_d;
      stat_mispreds_q <= stat_mispreds_d;
    end
  end

  assign pred_valid    = pred_valid_q;
  assign pred_taken    = pred_taken_q;
  assign pred_idx      = pred_idx_q;
  assign pred_ghr      = pred_ghr_q;
  assign ghr_out       = ghr_q;
  assign stat_preds    = stat_preds_q;
  assign stat_mispreds = stat_mispreds_q;
endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - directed and random checks of gshare_predictor
// against a behavioural table/history model.
module tb_gshare_predictor;
  logic       clk = 1'b0;
  logic       reset;
  logic       pred_req;
  logic [7:0] pred_pc;
  logic       pred_valid;
  logic       pred_taken;
  logic [2:0] pred_idx;
  logic [2:0] pred_ghr;
  logic       upd_en;
  logic [2:0] upd_idx;
  logic       upd_taken;
  logic       upd_mispredict;
  logic [2:0] upd_ghr;
  logic [2:0] ghr_out;
  logic [3:0] stat_preds;
  logic [3:0] stat_mispreds;

  int tests = 0;
  int fails = 0;

  int m_pht[8];
  int m_ghr, m_preds, m_mis, m_valid, m_taken, m_idx, m_pghr;

  gshare_predictor #(.GHR_BITS(3), .PC_BITS(8), .CTR_INIT(2'b01), .STAT_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_idx(pred_idx), .pred_ghr(pred_ghr),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr),
    .ghr_out(ghr_out), .stat_preds(stat_preds), .stat_mispreds(stat_mispreds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pht[i] = 1;
    m_ghr = 0; m_preds = 0; m_mis = 0;
    m_valid = 0; m_taken = 0; m_idx = 0; m_pghr = 0;
  endtask

  // Prediction reads the table before this edge's update lands.
  task automatic model_edge();
    int new_ghr;
    new_ghr = m_ghr;
    m_valid = pred_req;
    if (pred_req) begin
      m_idx   = (int'(pred_pc) % 8) ^ m_ghr;
      m_taken = (m_pht[m_idx] >= 2) ? 1 : 0;
      m_pghr  = m_ghr;
      new_ghr = (m_ghr * 2 + m_taken) % 8;
      if (m_preds < 15) m_preds++;
    end
    if (upd_en) begin
      if (upd_taken) m_pht[upd_idx] = (m_pht[upd_idx] == 3) ? 3 : m_pht[upd_idx] + 1;
      else           m_pht[upd_idx] = (m_pht[upd_idx] == 0) ? 0 : m_pht[upd_idx] - 1;
      if (upd_mispredict) begin
        new_ghr = (int'(upd_ghr) * 2 + int'(upd_taken)) % 8;
        if (m_mis < 15) m_mis++;
      end
    end
    m_ghr = new_ghr;
  endtask

  task automatic check_all();
    chk("pred_valid", pred_valid, m_valid);
    chk("pred_taken", pred_taken, m_taken);
    chk("pred_idx", pred_idx, m_idx);
    chk("pred_ghr", pred_ghr, m_pghr);
    chk("ghr_out", ghr_out, m_ghr);
    chk("stat_preds", stat_preds, m_preds);
    chk("stat_mispreds", stat_mispreds, m_mis);
  endtask

  task automatic idle();
    pred_req = 0; pred_pc = '0; upd_en = 0; upd_idx = '0;
    upd_taken = 0; upd_mispredict = 0; upd_ghr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic predict(input logic [7:0] pc);
    idle(); pred_req = 1; pred_pc = pc; step();
  endtask

  task automatic update(input logic [2:0] i, input logic t);
    idle(); upd_en = 1; upd_idx = i; upd_taken = t; step();
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    #12;
    check_all();
    reset = 0;

    // First prediction from reset.
    predict(8'h05);
    chk("first_idx", pred_idx, 5);
    chk("first_taken", pred_taken, 0);
    chk("first_ghr_out", ghr_out, 0);
    chk("first_stat", stat_preds, 1);

    // Saturate up, then predict taken.
    for (int k = 0; k < 4; k++) update(3'd5, 1'b1);
    predict(8'h05);
    chk("sat_up_taken", pred_taken, 1);
    chk("sat_up_ghr", ghr_out, 3'b001);

    // Saturate down; ghr=001 so pc 4 maps to index 5.
    for (int k = 0; k < 4; k++) update(3'd5, 1'b0);
    predict(8'h04);
    chk("sat_dn_idx", pred_idx, 5);
    chk("sat_dn_taken", pred_taken, 0);

    // Build ghr=101 speculatively, then recover in the same cycle as a request.
    update(3'd7, 1'b1);
    predict(8'h05);
    chk("spec_ghr", ghr_out, 3'b101);
    idle();
    pred_req = 1; pred_pc = 8'h00;
    upd_en = 1; upd_idx = 3'd0; upd_taken = 1; upd_mispredict = 1; upd_ghr = 3'b010;
    step();
    chk("recov_ghr", ghr_out, 3'b101);
    chk("recov_pred_ghr", pred_ghr, 3'b101);
    chk("recov_mis", stat_mispreds, 1);

    // Same-cycle predict and update on one index: no bypass.
    idle();
    pred_req = 1; pred_pc = 8'h01;
    upd_en = 1; upd_idx = 3'd4; upd_taken = 1;
    step();
    chk("nobypass_idx", pred_idx, 4);
    chk("nobypass_taken", pred_taken, 0);
    predict(8'h06);
    chk("after_upd_idx", pred_idx, 4);
    chk("after_upd_taken", pred_taken, 1);

    // Ignored mispredict without upd_en.
    idle(); upd_mispredict = 1; upd_ghr = 3'b111; step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      pred_req       = $urandom_range(0, 1);
      pred_pc        = 8'($urandom);
      upd_en         = ($urandom_range(0, 2) != 0);
      upd_idx        = 3'($urandom);
      upd_taken      = $urandom_range(0, 1);
      upd_mispredict = ($urandom_range(0, 3) == 0);
      upd_ghr        = 3'($urandom);
      step();
    end

    // Asynchronous reset with a prediction in flight.
    predict(8'h33);
    chk("inflight_valid", pred_valid, 1);
    idle(); pred_req = 1;
    #2;
    reset = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #3;
    reset = 0;
    idle();
    for (int i = 0; i < 8; i++) begin
      predict(8'(i * 5));
      chk("init_taken", pred_taken, 0);
    end

    // Statistics saturate at all-ones.
    for (int k = 0; k < 12; k++) predict(8'($urandom));
    chk("stat_sat", stat_preds, 15);
    for (int k = 0; k < 17; k++) begin
      idle(); upd_en = 1; upd_mispredict = 1; upd_idx = 3'($urandom); step();
    end
    chk("mis_sat", stat_mispreds, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
